// File: rtl/gpio_pkg.sv
// Shared constants, sequencer state type and bank-index type for the GPIO pin driver.
package gpio_pkg;

  localparam int unsigned DefPortWidth = 24;
  localparam int unsigned DefNumBank   = 6;
  localparam int unsigned DefBusWidth  = 32;
  localparam int unsigned BankIdxWidth = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    APPLY = 2'd2
  } seq_state_e;

  typedef logic [BankIdxWidth-1:0] bank_idx_t;

endpackage

// File: rtl/gpio_in_sync.sv
// Per-bank input synchroniser; with GPIO_CHANGE_IRQ_EN defined it also keeps the
// previous synchronised value and reports edges on pins marked as inputs.
module gpio_in_sync
  import gpio_pkg::*;
#(
  parameter int unsigned PortWidth = DefPortWidth
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [PortWidth-1:0] pin_in,
  input  logic [PortWidth-1:0] in_mask,
  output logic [PortWidth-1:0] sync,
  output logic [PortWidth-1:0] change
);

  logic [PortWidth-1:0] meta_reg;
  logic [PortWidth-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= pin_in;
      sync_reg <= meta_reg;
    end
  end

  assign sync = sync_reg;

`ifdef GPIO_CHANGE_IRQ_EN
  logic [PortWidth-1:0] prev_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= '0;
    end else begin
      prev_reg <= sync_reg;
    end
  end

  // Pins currently driven by us never report a change.
  assign change = (sync_reg ^ prev_reg) & in_mask;
`else
  logic unused_mask;
  assign unused_mask = ^in_mask;
  assign change      = '0;
`endif

endmodule

// File: rtl/gpio_pin_driver.sv
// GPIO pin driver: break-before-make direction sequencer, input synchronisers and,
// when GPIO_CHANGE_IRQ_EN is defined, sticky per-pin change flags with an irq line.
module gpio_pin_driver
  import gpio_pkg::*;
#(
  parameter int unsigned BusWidth   = DefBusWidth,
  parameter int unsigned PortWidth  = DefPortWidth,
  parameter int unsigned NumBank    = DefNumBank,
  parameter int unsigned TurnCycles = 2
) (
  input  logic                                CLOCK,
  input  logic                                reset_reg,
  input  logic [NumBank-1:0][BusWidth-1:0]    ddr_in,
  input  logic [NumBank-1:0][BusWidth-1:0]    out_in,
  input  logic                                update,
  input  logic [NumBank*PortWidth-1:0]        gpio_in,
  input  logic                                clr_strobe,
  input  bank_idx_t                           clr_bank,
  output logic [NumBank*PortWidth-1:0]        gpio_oe,
  output logic [NumBank*PortWidth-1:0]        gpio_out,
  output logic [NumBank*PortWidth-1:0]        gpio_sync,
  output logic [NumBank*PortWidth-1:0]        change_flags,
  output logic                                irq,
  output logic                                busy
);

  localparam int unsigned NumPin   = NumBank * PortWidth;
  localparam logic [3:0]  TurnLast = 4'(TurnCycles - 1);

  logic [NumPin-1:0] ddr_word, out_word, change_vec, clr_mask, turn_mask;

  seq_state_e        state_reg, state_next;
  logic [3:0]        turn_cnt_reg, turn_cnt_next;
  logic              pending_reg, pending_next;
  logic [NumPin-1:0] snap_ddr_reg, snap_ddr_next, snap_out_reg, snap_out_next;
  logic [NumPin-1:0] active_ddr_reg, active_ddr_next, active_out_reg, active_out_next;
  logic [NumPin-1:0] gpio_oe_reg, gpio_out_reg;
  logic              busy_reg;

  for (genvar gi = 0; gi < NumBank; gi++) begin : g_bank
    assign ddr_word[gi*PortWidth +: PortWidth] = ddr_in[gi][PortWidth-1:0];
    assign out_word[gi*PortWidth +: PortWidth] = out_in[gi][PortWidth-1:0];
    // Out-of-range bank indices simply match no bank.
    assign clr_mask[gi*PortWidth +: PortWidth] =
      {PortWidth{clr_strobe && (clr_bank == bank_idx_t'(gi))}};

    if (BusWidth > PortWidth) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^{ddr_in[gi][BusWidth-1:PortWidth], out_in[gi][BusWidth-1:PortWidth]};
    end

    gpio_in_sync #(.PortWidth(PortWidth)) u_in_sync (
      .clk    (CLOCK),
      .srst   (reset_reg),
      .pin_in (gpio_in[gi*PortWidth +: PortWidth]),
      .in_mask(~active_ddr_reg[gi*PortWidth +: PortWidth]),
      .sync   (gpio_sync[gi*PortWidth +: PortWidth]),
      .change (change_vec[gi*PortWidth +: PortWidth])
    );
  end

  always_comb begin
    state_next      = state_reg;
    turn_cnt_next   = turn_cnt_reg;
    pending_next    = pending_reg;
    snap_ddr_next   = snap_ddr_reg;
    snap_out_next   = snap_out_reg;
    active_ddr_next = active_ddr_reg;
    active_out_next = active_out_reg;
    case (state_reg)
      IDLE: begin
        turn_cnt_next = '0;
        if (update || pending_reg) begin
          snap_ddr_next = ddr_word;
          snap_out_next = out_word;
          pending_next  = 1'b0;
          state_next    = (ddr_word != active_ddr_reg) ? TURN : APPLY;
        end
      end
      TURN: begin
        if (update) pending_next = 1'b1;
        if (turn_cnt_reg == TurnLast) begin
          state_next = APPLY;
        end else begin
          turn_cnt_next = turn_cnt_reg + 4'd1;
        end
      end
      APPLY: begin
        if (update) pending_next = 1'b1;
        active_ddr_next = snap_ddr_reg;
        active_out_next = snap_out_reg;
        state_next      = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Only pins whose direction is about to flip are released during the turnaround.
  assign turn_mask = (state_reg == TURN) ? (snap_ddr_reg ^ active_ddr_reg) : '0;

  always_ff @(posedge CLOCK) begin
    if (reset_reg) begin
      state_reg      <= IDLE;
      turn_cnt_reg   <= '0;
      pending_reg    <= 1'b0;
      snap_ddr_reg   <= '0;
      snap_out_reg   <= '0;
      active_ddr_reg <= '0;
      active_out_reg <= '0;
      gpio_oe_reg    <= '0;
      gpio_out_reg   <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      turn_cnt_reg   <= turn_cnt_next;
      pending_reg    <= pending_next;
      snap_ddr_reg   <= snap_ddr_next;
      snap_out_reg   <= snap_out_next;
      active_ddr_reg <= active_ddr_next;
      active_out_reg <= active_out_next;
      gpio_oe_reg    <= active_ddr_reg & ~turn_mask;
      gpio_out_reg   <= active_out_reg & active_ddr_reg;
      busy_reg       <= (state_reg != IDLE);
    end
  end

  assign gpio_oe  = gpio_oe_reg;
  assign gpio_out = gpio_out_reg;
  assign busy     = busy_reg;

`ifdef GPIO_CHANGE_IRQ_EN
  logic [NumPin-1:0] flags_reg, flags_next;
  logic              irq_reg;

  // A set in the same cycle as a clear wins.
  assign flags_next = (flags_reg & ~clr_mask) | change_vec;

  always_ff @(posedge CLOCK) begin
    if (reset_reg) begin
      flags_reg <= '0;
      irq_reg   <= 1'b0;
    end else begin
      flags_reg <= flags_next;
      irq_reg   <= |flags_reg;
    end
  end

  assign change_flags = flags_reg;
  assign irq          = irq_reg;
`else
  logic unused_flags;
  assign unused_flags = ^{clr_mask, change_vec};
  assign change_flags = '0;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_pin_driver.sv
// Randomised self-checking bench for gpio_pin_driver with a cycle-history reference
// model plus directed scenarios with hand-computed expectations.
module tb_gpio_pin_driver;

  localparam int P  = 144;
  localparam int NB = 6;
  localparam int PW = 24;
  localparam int BW = 32;
  localparam int T  = 2;
  localparam int HN = 8192;
`ifdef GPIO_CHANGE_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic                     CLOCK = 1'b0;
  logic                     reset_reg;
  logic [NB-1:0][BW-1:0]    ddr_in, out_in;
  logic                     update;
  logic [P-1:0]             gpio_in;
  logic                     clr_strobe;
  logic [2:0]               clr_bank;
  logic [P-1:0]             gpio_oe, gpio_out, gpio_sync, change_flags;
  logic                     irq, busy;

  always #5 CLOCK = ~CLOCK;

  gpio_pin_driver #(.BusWidth(BW), .PortWidth(PW), .NumBank(NB), .TurnCycles(T)) dut (
    .CLOCK(CLOCK), .reset_reg(reset_reg), .ddr_in(ddr_in), .out_in(out_in), .update(update),
    .gpio_in(gpio_in), .clr_strobe(clr_strobe), .clr_bank(clr_bank), .gpio_oe(gpio_oe),
    .gpio_out(gpio_out), .gpio_sync(gpio_sync), .change_flags(change_flags), .irq(irq),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [P-1:0] act, input logic [P-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [P-1:0] hist [HN];
  int           cyc = 0;
  int           last_rst = -1;
  int           txn = 0;
  logic [P-1:0] m_act_ddr = '0, m_act_out = '0, m_snap_ddr = '0, m_snap_out = '0, m_chg_mask = '0;
  bit           m_pending = 1'b0, m_dirchg = 1'b0;
  int           m_left = 0;
  logic [P-1:0] exp_oe = '0, exp_out = '0, exp_sync = '0, exp_flags = '0;
  logic         exp_irq = 1'b0, exp_busy = 1'b0;

  function automatic logic [P-1:0] h(input int k);
    if (k <= last_rst || k < 0) return '0;
    return hist[k % HN];
  endfunction

  function automatic logic [P-1:0] flat(input logic [NB-1:0][BW-1:0] w);
    logic [P-1:0] r;
    for (int b = 0; b < NB; b++) r[b*PW +: PW] = w[b][PW-1:0];
    return r;
  endfunction

  always @(posedge CLOCK) begin
    logic [P-1:0] chg, clr;
    hist[cyc % HN] = gpio_in;
    if (reset_reg) begin
      m_act_ddr = '0; m_act_out = '0; m_snap_ddr = '0; m_snap_out = '0;
      m_pending = 1'b0; m_dirchg = 1'b0; m_left = 0; last_rst = cyc;
      exp_oe = '0; exp_out = '0; exp_sync = '0; exp_flags = '0; exp_irq = 1'b0; exp_busy = 1'b0;
    end else begin
      exp_oe   = m_act_ddr & ~((m_dirchg && m_left >= 2) ? m_chg_mask : '0);
      exp_out  = m_act_ddr & m_act_out;
      exp_busy = (m_left != 0);
      exp_sync = h(cyc - 1);
      if (IrqEn) begin
        exp_irq = |exp_flags;
        clr = '0;
        if (clr_strobe && int'(clr_bank) < NB) clr[int'(clr_bank)*PW +: PW] = '1;
        chg = (h(cyc - 2) ^ h(cyc - 3)) & ~m_act_ddr;
        exp_flags = (exp_flags & ~clr) | chg;
      end
      if (m_left != 0) begin
        if (update) m_pending = 1'b1;
        m_left--;
        if (m_left == 0) begin
          m_act_ddr = m_snap_ddr;
          m_act_out = m_snap_out;
        end
      end else if (update || m_pending) begin
        m_snap_ddr = flat(ddr_in);
        m_snap_out = flat(out_in);
        m_pending  = 1'b0;
        m_chg_mask = m_snap_ddr ^ m_act_ddr;
        m_dirchg   = |m_chg_mask;
        m_left     = m_dirchg ? T + 1 : 1;
        txn++;
        $display("txn %0d accepted at cycle %0d dir_change=%0d", txn, cyc, m_dirchg);
      end
    end
    cyc++;
  end

  always @(negedge CLOCK) begin
    if (model_on) begin
      chk("oe", gpio_oe, exp_oe);
      chk("out", gpio_out, exp_out);
      chk("sync", gpio_sync, exp_sync);
      chk("flags", change_flags, exp_flags);
      chk("irq", P'(irq), P'(exp_irq));
      chk("busy", P'(busy), P'(exp_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic pulse_update();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  initial begin
    int rises;
    bit prev_busy;
    int idx;
    reset_reg = 1'b1; update = 1'b0; ddr_in = '0; out_in = '0; gpio_in = '0;
    clr_strobe = 1'b0; clr_bank = '0;
    step(); step();
    reset_reg = 1'b0;
    model_on = 1'b1;
    chk("rst_oe", gpio_oe, '0);
    chk("rst_flags", change_flags, '0);
    chk("rst_busy", P'(busy), '0);

    // Direction change on bank 0: TURN for two cycles, outputs after edge 4.
    ddr_in[0] = 32'h0000_00FF; out_in[0] = 32'h0000_00A5;
    pulse_update();                                        // edge 0
    step(); chk("t1_oe_turn", P'(gpio_oe[7:0]), P'(8'h00)); // edge 1
    chk("t1_busy_e1", P'(busy), P'(1'b1));
    step(); step();                                        // edge 3
    chk("t1_oe_e3", P'(gpio_oe[7:0]), P'(8'h00));
    step();                                                // edge 4
    chk("t1_oe_e4", P'(gpio_oe[7:0]), P'(8'hFF));
    chk("t1_out_e4", P'(gpio_out[7:0]), P'(8'hA5));
    chk("t1_busy_e4", P'(busy), P'(1'b0));

    // Data-only update: no TURN, oe never drops.
    out_in[0] = 32'h0000_005A;
    pulse_update();
    step(); chk("t2_oe_e1", P'(gpio_oe[7:0]), P'(8'hFF));
    chk("t2_out_e1", P'(gpio_out[7:0]), P'(8'hA5));
    step(); chk("t2_oe_e2", P'(gpio_oe[7:0]), P'(8'hFF));
    chk("t2_out_e2", P'(gpio_out[7:0]), P'(8'h5A));

    // Three pulses one cycle apart, each with new words: two sequences run.
    rises = 0; prev_busy = busy;
    ddr_in[0] = 32'h0F; out_in[0] = 32'h01; pulse_update();
    if (busy && !prev_busy) rises++; prev_busy = busy;
    step(); if (busy && !prev_busy) rises++; prev_busy = busy;
    ddr_in[0] = 32'hF0; out_in[0] = 32'h02; pulse_update();
    if (busy && !prev_busy) rises++; prev_busy = busy;
    step(); if (busy && !prev_busy) rises++; prev_busy = busy;
    ddr_in[0] = 32'h3C; out_in[0] = 32'h2A; pulse_update();
    chk("t3_oe_first", P'(gpio_oe[7:0]), P'(8'h0F));
    if (busy && !prev_busy) rises++; prev_busy = busy;
    for (int i = 0; i < 10; i++) begin
      step(); if (busy && !prev_busy) rises++; prev_busy = busy;
    end
    chk("t3_seq_count", P'(rises), P'(2));
    chk("t3_oe_final", P'(gpio_oe[7:0]), P'(8'h3C));
    chk("t3_out_final", P'(gpio_out[7:0]), P'(8'h28));

    // Pin 30 (bank 1) is an input: flag three edges later, irq one after.
    gpio_in[30] = 1'b1;
    step(); step(); chk("t4_flag_e1", P'(change_flags[30]), P'(1'b0));
    step(); chk("t4_flag_e2", P'(change_flags[30]), P'(IrqEn));
    chk("t4_irq_e2", P'(irq), P'(1'b0));
    step(); chk("t4_irq_e3", P'(irq), P'(IrqEn));
    gpio_in[30] = 1'b0;
    step(); step();
    clr_strobe = 1'b1; clr_bank = 3'd1;
    step(); chk("t4_set_wins", P'(change_flags[30]), P'(IrqEn));
    step(); chk("t4_cleared", P'(change_flags[30]), P'(1'b0));
    clr_strobe = 1'b0;
    step(); chk("t4_irq_clr", P'(irq), P'(1'b0));

    // Pin 0 as output: toggling its input never raises a flag.
    ddr_in[0] = 32'hFF; out_in[0] = 32'h00; pulse_update();
    for (int i = 0; i < 5; i++) step();
    gpio_in[0] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("t5_out_pin_flag", P'(change_flags[0]), P'(1'b0));

    // Reset in the middle of TURN.
    ddr_in[0] = 32'h00; pulse_update();
    step(); chk("t6_busy_turn", P'(busy), P'(1'b1));
    reset_reg = 1'b1;
    step();
    chk("t6_rst_oe", gpio_oe, '0);
    chk("t6_rst_out", gpio_out, '0);
    chk("t6_rst_busy", P'(busy), P'(1'b0));
    reset_reg = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 2500; i++) begin
      update = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        for (int b = 0; b < NB; b++) ddr_in[b] = $urandom();
      for (int b = 0; b < NB; b++) out_in[b] = $urandom();
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, P - 1);
        gpio_in[idx] = ~gpio_in[idx];
      end
      clr_strobe = ($urandom_range(0, 9) == 0);
      clr_bank   = 3'($urandom_range(0, 7));
      reset_reg  = ($urandom_range(0, 599) == 0);
      step();
    end
    reset_reg = 1'b0; update = 1'b0; clr_strobe = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
